// File: rtl/rr_select_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin select arbiter.
package rr_select_arbiter_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Circular first-set search over 8 requests, starting just after 'last'.
module rr_pick8
  import rr_select_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    // k = 8 wraps back to 'last' itself, so it is considered lowest priority
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// One-slot output register fed by a round-robin grant over 8 channels through an external 8:1 mux.
module rr_select_arbiter
  import rr_select_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   gnt,
  output logic [2:0]        select,
  input  logic [DATA_W-1:0] mux_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_ch
);

  state_t           state, state_next;
  logic [2:0]       last, sel_hold, pick_idx;
  logic             pick_found, grant;

  rr_pick8 u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_valid = (state == FULL);

  // rst_n gates the grant so nothing is consumed while reset is held
  always_comb begin
    state_next = state;
    grant      = rst_n && pick_found && ((state == EMPTY) || out_ready);
    gnt        = '0;
    select     = sel_hold;
    if (grant) begin
      gnt[pick_idx] = 1'b1;
      select        = pick_idx;
      state_next    = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // 'last' resets to 7 so the first search begins at channel 0; select itself resets to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 3'd7;
      sel_hold <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else if (grant) begin
      last     <= pick_idx;
      sel_hold <= pick_idx;
      out_data <= mux_data;
      out_ch   <= pick_idx;
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed-vector bench for rr_select_arbiter with a behavioural 8:1 word mux.
`timescale 1ns/1ps
module tb_rr_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] select;
  logic [7:0] mux_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_ch;

  logic [7:0] ch_data [8];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_data = ch_data[select];

  rr_select_arbiter #(.DATA_W(8), .N_CH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .select    (select),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    checks++; if (select !== 3'd0) begin failures++; $display("FAIL reset_select got=%0d exp=0", select); end
    checks++; if (gnt !== 8'h00) begin failures++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    // fill the slot with ch2, then assert reset mid-cycle
    rst_n = 1'b1; req = 8'h04; out_ready = 1'b0;
    #1;
    checks++; if (gnt !== 8'h04) begin failures++; $display("FAIL first_gnt got=%h exp=04", gnt); end
    next_cycle();
    req = 8'h00;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h12) begin failures++; $display("FAIL pre_reset_full got=%0b/%h exp=1/12", out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL async_data got=%h exp=00", out_data); end
    checks++; if (select !== 3'd0) begin failures++; $display("FAIL async_select got=%0d exp=0", select); end
    next_cycle();
    rst_n = 1'b1; req = 8'h01; out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 8'h01) begin failures++; $display("FAIL post_reset_gnt got=%h exp=01", gnt); end
    next_cycle();
    checks++; if (out_ch !== 3'd0 || out_valid !== 1'b1 || out_data !== 8'h10) begin failures++; $display("FAIL post_reset_out got=%0d/%0b/%h exp=0/1/10", out_ch, out_valid, out_data); end
  endtask

  task automatic test_rotation;
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      #1;
      checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rot_gnt[%0d] got=%h exp=%h", k, gnt, exp_gnt); end
      next_cycle();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + (k % 8))) begin failures++; $display("FAIL rot_data[%0d] got=%0b/%h exp=1/%h", k, out_valid, out_data, 8'(8'h10 + (k % 8))); end
    end
  endtask

  task automatic test_skip_wrap;
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    next_cycle();
    checks++; if (out_ch !== 3'd5) begin failures++; $display("FAIL wrap_setup got=%0d exp=5", out_ch); end
    req = 8'h22;
    #1;
    checks++; if (gnt !== 8'h02 || select !== 3'd1) begin failures++; $display("FAIL wrap_gnt got=%h/%0d exp=02/1", gnt, select); end
    next_cycle();
    checks++; if (out_ch !== 3'd1 || out_data !== 8'h11) begin failures++; $display("FAIL wrap_out got=%0d/%h exp=1/11", out_ch, out_data); end
    #1;
    checks++; if (gnt !== 8'h20) begin failures++; $display("FAIL wrap_next_gnt got=%h exp=20", gnt); end
    next_cycle();
    checks++; if (out_ch !== 3'd5 || out_data !== 8'h15) begin failures++; $display("FAIL wrap_next_out got=%0d/%h exp=5/15", out_ch, out_data); end
  endtask

  task automatic test_stall_drain;
    do_reset();
    req = 8'hFF; out_ready = 1'b0;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt !== 8'h00 || select !== 3'd0) begin failures++; $display("FAIL stall_gnt[%0d] got=%h/%0d exp=00/0", k, gnt, select); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h10 || out_ch !== 3'd0) begin failures++; $display("FAIL stall_hold[%0d] got=%0b/%h/%0d exp=1/10/0", k, out_valid, out_data, out_ch); end
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 8'h02) begin failures++; $display("FAIL stall_release_gnt got=%h exp=02", gnt); end
    next_cycle();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 3'd1) begin failures++; $display("FAIL stall_release_out got=%0b/%h/%0d exp=1/11/1", out_valid, out_data, out_ch); end
    req = 8'h00;
    #1;
    checks++; if (gnt !== 8'h00 || select !== 3'd1) begin failures++; $display("FAIL drain_gnt got=%h/%0d exp=00/1", gnt, select); end
    next_cycle();
    checks++; if (out_valid !== 1'b0 || select !== 3'd1) begin failures++; $display("FAIL drain_out got=%0b/%0d exp=0/1", out_valid, select); end
  endtask

  task automatic test_hog;
    do_reset();
    req = 8'h80; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (gnt !== 8'h80 || select !== 3'd7) begin failures++; $display("FAIL hog_gnt[%0d] got=%h/%0d exp=80/7", k, gnt, select); end
      next_cycle();
      checks++; if (out_valid !== 1'b1 || out_ch !== 3'd7 || out_data !== 8'h17) begin failures++; $display("FAIL hog_out[%0d] got=%0b/%0d/%h exp=1/7/17", k, out_valid, out_ch, out_data); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch_data[i] = 8'(8'h10 + i);
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_stall_drain();
    test_hog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
